round_robin_arbiter: RTL and testbench
======================================

Name: round_robin_arbiter

Overview:
- Packet-level round-robin arbiter for one master port of the streaming crossbar. Picks one of S_DATA_COUNT slave requesters and holds the grant until that packet's last beat. The pointer then rotates past the winner.
- Drives the per-slave grant vector plus the master-side id/valid/last sideband. Data muxing sits outside this block.

Parameters:
- S_DATA_COUNT, 5, number of requesting slave ports (≥2).
- T_ID___WIDTH, $clog2(S_DATA_COUNT), width of the granted-source index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- request_mask_i  in  S_DATA_COUNT  bit i = slave i has a beat pending for this master.
- s_last_i  in  S_DATA_COUNT  bit i = slave i's current beat is the packet's last.
- grant_o  out  S_DATA_COUNT  one-hot (or zero) grant to slave i.
- m_last_o  out  1  granted beat is last of packet.
- m_id_o  out  T_ID___WIDTH  index of the granted slave.
- m_valid_o  out  1  a granted beat is present this cycle.

Behaviour:
- State registers:
  - ptr: highest-priority index, 0..S-1.
  - locked: 1 bit.
  - owner: T_ID___WIDTH bits.
- Reset (rst=0, async): ptr=0, locked=0, owner=0. Outputs are combinational from state and inputs, so with no requests all outputs are 0.
- Unlocked selection (combinational):
  - Winner = first i with request_mask_i[i]=1, scanning ptr, ptr+1, …, S-1, 0, …, ptr-1 (wrap-around).
  - No request → grant_o=0, m_valid_o=0, m_id_o=0, m_last_o=0.
- Locked: winner = owner regardless of other requests. grant_o = onehot(owner).
- Outputs:
  - m_valid_o = request_mask_i[winner] & (a winner exists).
  - m_id_o = winner index when m_valid_o=1, else 0 in unlocked/idle. When locked, m_id_o = owner.
  - m_last_o = m_valid_o & s_last_i[winner].
- Locked with request_mask_i[owner]=0: grant_o stays onehot(owner), m_valid_o=0, m_last_o=0, state held. This is a bubble mid-packet.
- Every beat with m_valid_o=1 is consumed that cycle; there is no ready input.
- Clock-edge update:
  - m_valid_o & m_last_o → locked<=0, ptr<=(winner+1) mod S_DATA_COUNT (wraps S-1→0). This includes single-beat packets while unlocked; that source is never locked.
  - m_valid_o & !m_last_o → locked<=1, owner<=winner.
  - Otherwise → hold all state.
- s_last_i bits of non-granted slaves are ignored.
- Reset asserted mid-packet drops the lock immediately; ptr returns to 0.
- Latency: grant appears in the same cycle as the request (0 cycles). Re-arbitration takes effect on the cycle after the last beat.
- grant_o is never multi-hot.

Decomposition:
- Shared crossbar package: S_DATA_COUNT default and the id-width derivation, for reuse by crossbar top and mux.
- One sub-module, rr_priority_select: rotating-priority encoder (inputs: request vector, ptr; outputs: found flag, index).
- The top holds the registers and the lock/owner override.

Test Plan:
- Reset, then request=01000, last=0 → grant=08, id=3, valid=1, last=0; next cycle locked on 3.
- Locked on 3; request=11111, last=01000 → grant=08, id=3, last=1. Then request=10101, last=0 → grant=10, id=4 (ptr was 4).
- Locked on 4; request=10000, last=0 → grant=10, last=0. Then last=10000 → grant=10, last=1; ptr wraps to 0.
- Walk: request=11111 with last=00000, then 00001, 00010, 00100, 01000 each cycle.
  - Grants 01, 01, 02, 04, 08; ids 0, 0, 1, 2, 3.
  - last=1 on the cycles where the last bit matches the granted id.
- request=00000 while unlocked → grant=0, valid=0, id=0, last=0.
- Locked owner drops its request mid-packet → grant=onehot(owner), valid=0; other requesters are not granted until owner's last beat. Assert rst=0 mid-packet → outputs 0 while asserted; after release, selection starts from ptr=0.

Source files
------------

// File: rtl/round_robin_arbiter_pkg.sv
// Shared crossbar definitions: default slave count, id-width derivation and
// the per-cycle state update actions used by the arbiter.
package round_robin_arbiter_pkg;

  localparam int RR_S_DATA_COUNT = 5;

  function automatic int rr_id_width(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    ARB_HOLD    = 2'd0,
    ARB_LOCK    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_action_e;

endpackage

// File: rtl/round_robin_arbiter_priority_select.sv
// Rotating-priority encoder: first set request bit at or after ptr, wrapping
// from S-1 back to 0.
module rr_priority_select
  import round_robin_arbiter_pkg::*;
#(
  parameter int S = RR_S_DATA_COUNT,
  parameter int W = rr_id_width(RR_S_DATA_COUNT)
) (
  input  logic [S-1:0] request,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  logic [2*S-1:0] doubled;
  logic [S-1:0]   rotated;
  int             sum;

  // Rotate so that bit 0 of rotated corresponds to slave ptr.
  assign doubled = {request, request} >> ptr;
  assign rotated = doubled[S-1:0];

  always_comb begin
    found = 1'b0;
    index = '0;
    sum   = 0;
    for (int k = 0; k < S; k++) begin
      if (!found && rotated[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= S) sum = sum - S;
        index = W'(sum);
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Packet-level round-robin arbiter for one crossbar master port: grants one
// slave and holds it until that packet's last beat, then rotates past it.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int S_DATA_COUNT = RR_S_DATA_COUNT,
  parameter int T_ID___WIDTH = rr_id_width(S_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_COUNT-1:0] request_mask_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic                    m_last_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_valid_o
);

  logic [T_ID___WIDTH-1:0] ptr;
  logic                    locked;
  logic [T_ID___WIDTH-1:0] owner;

  logic                    sel_found;
  logic [T_ID___WIDTH-1:0] sel_index;
  logic                    have_winner;
  logic [T_ID___WIDTH-1:0] winner;
  logic [T_ID___WIDTH-1:0] next_ptr;
  arb_action_e             action;

  rr_priority_select #(
    .S (S_DATA_COUNT),
    .W (T_ID___WIDTH)
  ) u_select (
    .request (request_mask_i),
    .ptr     (ptr),
    .found   (sel_found),
    .index   (sel_index)
  );

  // Handshake: there is no ready; a beat with m_valid_o=1 is consumed in the
  // same cycle. While locked, the grant stays on the owner even through
  // bubbles (owner request low), so other slaves cannot interleave a packet.
  always_comb begin
    have_winner = 1'b0;
    winner      = '0;
    if (locked) begin
      have_winner = 1'b1;
      winner      = owner;
    end else if (sel_found) begin
      have_winner = 1'b1;
      winner      = sel_index;
    end
  end

  always_comb begin
    grant_o   = '0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_id_o    = '0;
    if (have_winner) begin
      grant_o   = {{(S_DATA_COUNT-1){1'b0}}, 1'b1} << winner;
      m_valid_o = request_mask_i[winner];
      m_last_o  = request_mask_i[winner] & s_last_i[winner];
      m_id_o    = winner;
    end
  end

  always_comb begin
    action = ARB_HOLD;
    if (m_valid_o && m_last_o) action = ARB_RELEASE;
    else if (m_valid_o)        action = ARB_LOCK;
    next_ptr = (winner == T_ID___WIDTH'(S_DATA_COUNT-1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      locked <= 1'b0;
      owner  <= '0;
    end else begin
      case (action)
        ARB_RELEASE: begin
          locked <= 1'b0;
          ptr    <= next_ptr;
        end
        ARB_LOCK: begin
          locked <= 1'b1;
          owner  <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed packet scenarios plus randomized
// traffic checked against a packet-level reference model.
module tb_round_robin_arbiter;

  localparam int S = 5;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [S-1:0] request_mask_i;
  logic [S-1:0] s_last_i;
  logic [S-1:0] grant_o;
  logic         m_last_o;
  logic [W-1:0] m_id_o;
  logic         m_valid_o;

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic [S-1:0] req;
    logic [S-1:0] last;
    logic [S-1:0] grant;
    logic [W-1:0] id;
    logic         valid;
    logic         lst;
  } row_t;

  round_robin_arbiter #(
    .S_DATA_COUNT (S),
    .T_ID___WIDTH (W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .request_mask_i (request_mask_i),
    .s_last_i       (s_last_i),
    .grant_o        (grant_o),
    .m_last_o       (m_last_o),
    .m_id_o         (m_id_o),
    .m_valid_o      (m_valid_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: change inputs just after the active edge, sample at the negedge
  task automatic drive(input logic [S-1:0] req, input logic [S-1:0] last);
    @(posedge clk);
    #1;
    request_mask_i = req;
    s_last_i       = last;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    request_mask_i = '0;
    s_last_i       = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    request_mask_i = '0;
    s_last_i       = '0;
    @(negedge clk);
    n_cmp++;
    if ({grant_o, m_id_o, m_valid_o, m_last_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got grant=%b id=%0d valid=%b last=%b, want all 0",
               grant_o, m_id_o, m_valid_o, m_last_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_packets();
    row_t rows [11];
    rows = '{
      '{5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b1, 1'b0},
      '{5'b11111, 5'b01000, 5'b01000, 3'd3, 1'b1, 1'b1},
      '{5'b10101, 5'b00000, 5'b10000, 3'd4, 1'b1, 1'b0},
      '{5'b10000, 5'b00000, 5'b10000, 3'd4, 1'b1, 1'b0},
      '{5'b10000, 5'b10000, 5'b10000, 3'd4, 1'b1, 1'b1},
      '{5'b11111, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0},
      '{5'b11111, 5'b00001, 5'b00001, 3'd0, 1'b1, 1'b1},
      '{5'b11111, 5'b00010, 5'b00010, 3'd1, 1'b1, 1'b1},
      '{5'b11111, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b1},
      '{5'b11111, 5'b01000, 5'b01000, 3'd3, 1'b1, 1'b1},
      '{5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 11; i++) begin
      drive(rows[i].req, rows[i].last);
      n_cmp++;
      if ({grant_o, m_id_o, m_valid_o, m_last_o} !==
          {rows[i].grant, rows[i].id, rows[i].valid, rows[i].lst}) begin
        n_err++;
        $display("FAIL packets[%0d]: got grant=%b id=%0d valid=%b last=%b, want grant=%b id=%0d valid=%b last=%b",
                 i, grant_o, m_id_o, m_valid_o, m_last_o,
                 rows[i].grant, rows[i].id, rows[i].valid, rows[i].lst);
      end
    end
  endtask

  // Enters with ptr=4 and unlocked (after test_packets).
  task automatic test_bubble();
    row_t rows [6];
    rows = '{
      '{5'b11111, 5'b00000, 5'b10000, 3'd4, 1'b1, 1'b0},
      '{5'b01111, 5'b11111, 5'b10000, 3'd4, 1'b0, 1'b0},
      '{5'b01111, 5'b00000, 5'b10000, 3'd4, 1'b0, 1'b0},
      '{5'b11111, 5'b10000, 5'b10000, 3'd4, 1'b1, 1'b1},
      '{5'b00110, 5'b00000, 5'b00010, 3'd1, 1'b1, 1'b0},
      '{5'b11101, 5'b00000, 5'b00010, 3'd1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      drive(rows[i].req, rows[i].last);
      n_cmp++;
      if ({grant_o, m_id_o, m_valid_o, m_last_o} !==
          {rows[i].grant, rows[i].id, rows[i].valid, rows[i].lst}) begin
        n_err++;
        $display("FAIL bubble[%0d]: got grant=%b id=%0d valid=%b last=%b, want grant=%b id=%0d valid=%b last=%b",
                 i, grant_o, m_id_o, m_valid_o, m_last_o,
                 rows[i].grant, rows[i].id, rows[i].valid, rows[i].lst);
      end
    end
  endtask

  // Enters locked on slave 1 mid-packet.
  task automatic test_reset_mid_packet();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    request_mask_i = '0;
    s_last_i       = '0;
    @(negedge clk);
    n_cmp++;
    if ({grant_o, m_id_o, m_valid_o, m_last_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_packet: got grant=%b id=%0d valid=%b last=%b, want all 0",
               grant_o, m_id_o, m_valid_o, m_last_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(5'b11110, 5'b00000);
    n_cmp++;
    if ({grant_o, m_id_o, m_valid_o, m_last_o} !== {5'b00010, 3'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL after_reset_ptr0: got grant=%b id=%0d valid=%b last=%b, want grant=00010 id=1 valid=1 last=0",
               grant_o, m_id_o, m_valid_o, m_last_o);
    end
    drive(5'b11101, 5'b00000);
    n_cmp++;
    if ({grant_o, m_id_o, m_valid_o} !== {5'b00010, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL relock_after_reset: got grant=%b id=%0d valid=%b, want grant=00010 id=1 valid=0",
               grant_o, m_id_o, m_valid_o);
    end
  endtask

  // Random traffic against a packet-level model: a current owner (or none)
  // and the next slave in line for priority.
  task automatic test_random();
    int           m_ptr;
    int           m_owner;
    int           w;
    logic [S-1:0] req;
    logic [S-1:0] last;
    logic [S-1:0] e_grant;
    logic [W-1:0] e_id;
    logic         e_valid;
    logic         e_last;
    pulse_reset();
    m_ptr   = 0;
    m_owner = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req  = S'($urandom_range(0, (1 << S) - 1));
      if ($urandom_range(0, 7) == 0) req = '0;
      last = S'($urandom & $urandom);
      drive(req, last);
      w = -1;
      if (m_owner >= 0) w = m_owner;
      else
        for (int k = 0; k < S; k++)
          if (w < 0 && req[(m_ptr + k) % S]) w = (m_ptr + k) % S;
      e_grant = '0;
      e_id    = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (w >= 0) begin
        e_grant[w] = 1'b1;
        e_id       = W'(w);
        e_valid    = req[w];
        e_last     = req[w] & last[w];
      end
      n_cmp++;
      if ({grant_o, m_id_o, m_valid_o, m_last_o} !== {e_grant, e_id, e_valid, e_last}) begin
        n_err++;
        $display("FAIL random[%0d] req=%b last=%b: got grant=%b id=%0d valid=%b last=%b, want grant=%b id=%0d valid=%b last=%b",
                 cyc, req, last, grant_o, m_id_o, m_valid_o, m_last_o,
                 e_grant, e_id, e_valid, e_last);
      end
      n_cmp++;
      if ($countones(grant_o) > 1) begin
        n_err++;
        $display("FAIL random_onehot[%0d]: got grant=%b, want at most one bit set", cyc, grant_o);
      end
      if (e_valid && e_last) begin
        m_owner = -1;
        m_ptr   = (w + 1) % S;
      end else if (e_valid) begin
        m_owner = w;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_packets();
    test_bubble();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
